// File: rtl/vid_sync_lock_ctrl.sv
// ---------------------------------------------------------------------------
// vid_sync_lock_ctrl
//
// Supervises the clocked-video input once sync polarity has been normalised.
// Measures pixels per line (from data-valid) and lines per frame (between
// vsync rising edges), and declares lock after LOCK_FRAMES consecutive frames
// measure identically. The partial frame seen on leaving SYNC is frame 0 and
// is always discarded.
//
// Ports
//   clk           in   video clock
//   rst           in   asynchronous reset, active-high
//   enable        in   level enable; low forces IDLE and clears measurement
//   vid_de        in   active-video data valid
//   vid_vsync     in   vsync, active-high
//   locked        out  active_width/active_height valid and stable
//   active_width  out  locked pixels per line (held after lock loss)
//   active_height out  locked lines per frame (held after lock loss)
//   lock_lost     out  one-cycle pulse whenever LOCKED is left (not on rst)
// ---------------------------------------------------------------------------
module vid_sync_lock_ctrl #(
    parameter int CNT_W       = 12,
    parameter int LOCK_FRAMES = 3,
    parameter int TIMEOUT     = 2000000,
    parameter int TMO_W       = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             vid_de,
    input  logic             vid_vsync,
    output logic             locked,
    output logic [CNT_W-1:0] active_width,
    output logic [CNT_W-1:0] active_height,
    output logic             lock_lost
);

    localparam int                MW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0]     LOCK_TGT = MW'(LOCK_FRAMES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_MEASURE, S_LOCKED} state_t;

    state_t             r_state;
    logic               r_de_q, r_vs_q;
    logic [CNT_W-1:0]   r_pix, r_line, r_fw;
    logic               r_bad, r_sat;
    logic [TMO_W-1:0]   r_tmo;
    logic [MW-1:0]      r_match;
    logic [CNT_W-1:0]   r_cand_w, r_cand_h;
    logic               r_cand_vld;
    logic               r_locked, r_lost;
    logic [CNT_W-1:0]   r_act_w, r_act_h;

    logic               w_vs_rise, w_de_fall, w_run;
    logic [CNT_W-1:0]   w_line_nxt, w_fw_nxt;
    logic               w_bad_nxt, w_sat_nxt, w_frame_ok, w_match_cand, w_match_act;
    state_t             w_state_nxt;
    logic               w_locked_nxt, w_lost_nxt, w_cand_vld_nxt;
    logic [CNT_W-1:0]   w_act_w_nxt, w_act_h_nxt, w_cand_w_nxt, w_cand_h_nxt;
    logic [MW-1:0]      w_match_nxt, w_match_inc;
    logic [TMO_W-1:0]   w_tmo_nxt;

    assign w_vs_rise   = vid_vsync & ~r_vs_q;
    assign w_de_fall   = r_de_q & ~vid_de;
    assign w_run       = enable && (r_state != S_IDLE);
    assign w_match_inc = r_match + MW'(1);

    // Frame statistics with this cycle's line end folded in, so a de_fall that
    // coincides with vs_rise is counted into the frame that is closing.
    always_comb begin
        w_line_nxt = r_line;
        w_fw_nxt   = r_fw;
        w_bad_nxt  = r_bad;
        w_sat_nxt  = r_sat;
        if (w_de_fall) begin
            if (r_line != CNT_MAX) w_line_nxt = r_line + CNT_W'(1);
            if (r_line == '0)         w_fw_nxt  = r_pix;
            else if (r_pix != r_fw)   w_bad_nxt = 1'b1;
            if (r_pix == CNT_MAX || w_line_nxt == CNT_MAX) w_sat_nxt = 1'b1;
        end
    end

    assign w_frame_ok   = !w_bad_nxt && !w_sat_nxt && (w_fw_nxt != '0) && (w_line_nxt != '0);
    assign w_match_cand = w_frame_ok && r_cand_vld && (w_fw_nxt == r_cand_w) && (w_line_nxt == r_cand_h);
    assign w_match_act  = w_frame_ok && (w_fw_nxt == r_act_w) && (w_line_nxt == r_act_h);

    // Edge registers and per-frame measurement counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de_q <= 1'b0;
            r_vs_q <= 1'b0;
            r_pix  <= '0;
            r_line <= '0;
            r_fw   <= '0;
            r_bad  <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_de_q <= vid_de;
            r_vs_q <= vid_vsync;
            if (!w_run) begin
                r_pix  <= '0;
                r_line <= '0;
                r_fw   <= '0;
                r_bad  <= 1'b0;
                r_sat  <= 1'b0;
            end else begin
                if (w_de_fall)                     r_pix <= '0;
                else if (vid_de && r_pix != CNT_MAX) r_pix <= r_pix + CNT_W'(1);
                if (w_vs_rise) begin
                    r_line <= '0;
                    r_fw   <= '0;
                    r_bad  <= 1'b0;
                    r_sat  <= 1'b0;
                end else begin
                    r_line <= w_line_nxt;
                    r_fw   <= w_fw_nxt;
                    r_bad  <= w_bad_nxt;
                    r_sat  <= w_sat_nxt;
                end
            end
        end
    end

    // Lock FSM: state and qualifier registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tmo      <= '0;
            r_match    <= '0;
            r_cand_w   <= '0;
            r_cand_h   <= '0;
            r_cand_vld <= 1'b0;
            r_locked   <= 1'b0;
            r_lost     <= 1'b0;
            r_act_w    <= '0;
            r_act_h    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tmo      <= w_tmo_nxt;
            r_match    <= w_match_nxt;
            r_cand_w   <= w_cand_w_nxt;
            r_cand_h   <= w_cand_h_nxt;
            r_cand_vld <= w_cand_vld_nxt;
            r_locked   <= w_locked_nxt;
            r_lost     <= w_lost_nxt;
            r_act_w    <= w_act_w_nxt;
            r_act_h    <= w_act_h_nxt;
        end
    end

    // Lock FSM: next state. Priority is enable, then timeout, then vs_rise.
    always_comb begin
        w_state_nxt    = r_state;
        w_locked_nxt   = r_locked;
        w_lost_nxt     = 1'b0;
        w_act_w_nxt    = r_act_w;
        w_act_h_nxt    = r_act_h;
        w_cand_w_nxt   = r_cand_w;
        w_cand_h_nxt   = r_cand_h;
        w_cand_vld_nxt = r_cand_vld;
        w_match_nxt    = r_match;
        w_tmo_nxt      = (r_state == S_IDLE || w_vs_rise) ? '0 : r_tmo + TMO_W'(1);

        if (!enable) begin
            w_state_nxt    = S_IDLE;
            w_locked_nxt   = 1'b0;
            w_lost_nxt     = (r_state == S_LOCKED);
            w_match_nxt    = '0;
            w_cand_vld_nxt = 1'b0;
            w_tmo_nxt      = '0;
        end else if (r_state != S_IDLE && !w_vs_rise && r_tmo == TMO_LAST) begin
            w_state_nxt  = S_SYNC;
            w_locked_nxt = 1'b0;
            w_lost_nxt   = (r_state == S_LOCKED);
            w_tmo_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_SYNC;
                S_SYNC: begin
                    if (w_vs_rise) begin
                        w_state_nxt    = S_MEASURE;
                        w_match_nxt    = '0;
                        w_cand_vld_nxt = 1'b0;
                    end
                end
                S_MEASURE: begin
                    if (w_vs_rise) begin
                        if (w_match_cand && w_match_inc == LOCK_TGT) begin
                            w_state_nxt    = S_LOCKED;
                            w_locked_nxt   = 1'b1;
                            w_act_w_nxt    = w_fw_nxt;
                            w_act_h_nxt    = w_line_nxt;
                            w_match_nxt    = '0;
                            w_cand_vld_nxt = 1'b0;
                        end else if (w_match_cand) begin
                            w_match_nxt = w_match_inc;
                        end else begin
                            w_cand_w_nxt   = w_fw_nxt;
                            w_cand_h_nxt   = w_line_nxt;
                            w_cand_vld_nxt = w_frame_ok;
                            w_match_nxt    = '0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_vs_rise && !w_match_act) begin
                        w_state_nxt    = S_MEASURE;
                        w_locked_nxt   = 1'b0;
                        w_lost_nxt     = 1'b1;
                        w_cand_w_nxt   = w_fw_nxt;
                        w_cand_h_nxt   = w_line_nxt;
                        w_cand_vld_nxt = w_frame_ok;
                        w_match_nxt    = '0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign locked        = r_locked;
    assign lock_lost     = r_lost;
    assign active_width  = r_act_w;
    assign active_height = r_act_h;

endmodule
